uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: width of one UART character.
REQ-002 Parameter DEPTH, default 8: number of storage entries; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  host push request, qualified by clk.
REQ-006 wr_data  input  DATA_W  character to push.
REQ-007 tx_fifo_shift  input  1  pop request from the TX controller; one-cycle pulse in its LOAD state.
REQ-008 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 rd_data  output  DATA_W  head-of-queue character, first-word-fall-through.
REQ-010 tx_valid  output  1  queue non-empty; drives the TX controller's valid_in.
REQ-011 full  output  1  all DEPTH entries occupied.
REQ-012 empty  output  1  no entries occupied.
REQ-013 overflow  output  1  sticky flag: a push was dropped.
REQ-014 level  output  $clog2(DEPTH)+1  occupancy count; present only with UART_TX_FIFO_LEVEL_EN.

Function
REQ-015 Storage: DEPTH x DATA_W register array; write and read pointers, $clog2(DEPTH) bits each; occupancy counter, $clog2(DEPTH)+1 bits.
REQ-016 Pointers wrap naturally from DEPTH-1 to 0; no explicit compare against DEPTH.
REQ-017 Push accepted when wr_en=1 and (full=0 or tx_fifo_shift=1 with empty=0):
- wr_data written at the write pointer.
- Write pointer +1 on the same edge.
REQ-018 Pop accepted when tx_fifo_shift=1 and empty=0:
- Read pointer +1 on the same edge.
REQ-019 rd_data is combinationally the entry at the read pointer.
- Valid whenever tx_valid=1, in the same cycle as the controller's load pulse.
- Zero-latency; no output register.
REQ-020 A character pushed at edge N appears on rd_data with tx_valid=1 after edge N; fall-through latency 1 cycle.
REQ-021 Occupancy update: push only +1; pop only -1; both or neither, unchanged.
REQ-022 Flags are decoded from occupancy: empty=(count==0), full=(count==DEPTH), tx_valid=~empty.
REQ-023 Push while full with no accepted pop: data dropped, pointers and array unchanged, overflow set at that edge.
REQ-024 Pop while empty: ignored; no pointer, count or flag change.
REQ-025 Simultaneous push and pop:
- When full: both accepted; full stays 1.
- When empty: push accepted, pop ignored.
REQ-026 clr_ovf=1 clears overflow at the next edge; a same-cycle overflow event has priority and leaves it set.

Reset
REQ-027 reset=1 asynchronously sets both pointers and the count to 0 and clears overflow.
REQ-028 Reset output values: empty=1, tx_valid=0, full=0, overflow=0, level=0.
REQ-029 Array contents are not reset; rd_data is don't-care while empty.
REQ-030 Reset during traffic discards all queued characters; the first push after release is the next character delivered.

Configuration
REQ-031 Macro UART_TX_FIFO_LEVEL_EN.
- Defined: the level port exists and equals the occupancy count.
- Undefined: the level port is absent; all other behaviour is identical.

Verification
REQ-032 Bench covers the following directed scenarios:
- Reset, then idle -> empty=1, tx_valid=0, full=0, overflow=0, level=0.
- Push 0x41 at one edge -> next cycle tx_valid=1, rd_data=0x41, level=1; pulse tx_fifo_shift -> empty=1.
- Push 0x00..0x07 (DEPTH=8) -> full=1, level=8; push 0xFF -> overflow=1, level stays 8, and eight pops return 0x00..0x07 in order.
- Fill to full, then push 0xAA and pop in the same cycle -> full stays 1, pop returns 0x00 first, 0xAA last.
- Pop while empty -> no flag or level change; push while empty with a simultaneous pop -> level=1.
- Three characters queued, assert reset mid-stream -> empty=1 immediately; after release, push 0x55 -> rd_data=0x55.
- With the TX controller attached: queue "HI" -> two LOAD pulses, serial frames 0x48 then 0x49, tx_valid=0 after the second pop.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host push / TX controller pop bundle for uart_tx_fifo.
// level is only present when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if #(parameter int DATA_W = 8, parameter int DEPTH = 8);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              tx_fifo_shift;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              tx_valid;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif
  modport master (
    output wr_en, wr_data, tx_fifo_shift, clr_ovf,
    input  rd_data, tx_valid, full, empty, overflow
`ifdef UART_TX_FIFO_LEVEL_EN
    , level
`endif
  );
  modport slave (
    input  wr_en, wr_data, tx_fifo_shift, clr_ovf,
    output rd_data, tx_valid, full, empty, overflow
`ifdef UART_TX_FIFO_LEVEL_EN
    , level
`endif
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through character queue feeding a UART TX controller.
// Define UART_TX_FIFO_LEVEL_EN to expose the occupancy count on bus.level.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_empty, w_full, w_pop, w_push, w_ovf_evt;
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == (AW+1)'(DEPTH);
  assign w_pop     = bus.tx_fifo_shift && !w_empty;
  // a pop on the same edge frees the slot, so a push into a full queue still lands
  assign w_push    = bus.wr_en && (!w_full || w_pop);
  assign w_ovf_evt = bus.wr_en && !w_push;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= bus.wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + AW'(w_push);
      r_rptr     <= r_rptr + AW'(w_pop);
      r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_overflow <= w_ovf_evt || (r_overflow && !bus.clr_ovf);
    end
  assign bus.rd_data  = r_mem[r_rptr];
  assign bus.tx_valid = !w_empty;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level    = r_count;
`endif
endmodule
